// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared widths and matrix types for the 2x2 matrix multiplier
package matmul_pkg;

  // Operand element width (unsigned)
  localparam int DW = 8;
  // Exact width of one element product
  localparam int PW = 2 * DW;
  // Width of a sum of two products; wide enough that it can never overflow
  localparam int SW = 2 * DW + 1;

  // 2x2 operand matrix, row-major: [0]=M00 [1]=M01 [2]=M10 [3]=M11
  typedef logic [3:0][DW-1:0] mat2_t;
  // 2x2 result matrix, same row-major ordering
  typedef logic [3:0][SW-1:0] res2_t;

endpackage

// File: rtl/matmul_dot2.sv
// rtl/matmul_dot2.sv - two-stage x0*y0 + x1*y1 for one result element
module dot2 #(
  parameter int W = matmul_pkg::DW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_adv,
  input  logic [W-1:0]   i_x0,
  input  logic [W-1:0]   i_y0,
  input  logic [W-1:0]   i_x1,
  input  logic [W-1:0]   i_y1,
  output logic [2*W:0]   o_sum
);
  import matmul_pkg::*;

  logic [2*W-1:0] w_m0;
  logic [2*W-1:0] w_m1;
  logic [2*W-1:0] r_p0;
  logic [2*W-1:0] r_p1;
  logic [2*W:0]   r_sum;

  // Zero-extend before multiplying so the full product width is kept
  assign w_m0 = {{W{1'b0}}, i_x0} * {{W{1'b0}}, i_y0};
  assign w_m1 = {{W{1'b0}}, i_x1} * {{W{1'b0}}, i_y1};

  // Products in stage 1, their carry-preserving sum in stage 2; both hold when i_adv is low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0  <= '0;
      r_p1  <= '0;
      r_sum <= '0;
    end else if (i_adv) begin
      r_p0  <= w_m0;
      r_p1  <= w_m1;
      r_sum <= {1'b0, r_p0} + {1'b0, r_p1};
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/matmul_pipe.sv
// rtl/matmul_pipe.sv - two-stage pipelined 2x2 matrix multiplier with valid/ready flow control
module matmul_pipe #(
  parameter int DW = matmul_pkg::DW,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   i_a0,
  input  logic [DW-1:0]   i_a1,
  input  logic [DW-1:0]   i_a2,
  input  logic [DW-1:0]   i_a3,
  input  logic [DW-1:0]   i_b0,
  input  logic [DW-1:0]   i_b1,
  input  logic [DW-1:0]   i_b2,
  input  logic [DW-1:0]   i_b3,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output logic [2*DW:0]   o_c0,
  output logic [2*DW:0]   o_c1,
  output logic [2*DW:0]   o_c2,
  output logic [2*DW:0]   o_c3,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [CW-1:0]   o_mat_count
);
  import matmul_pkg::*;

  logic          w_adv;
  logic          r_v1;
  logic          r_out_valid;
  logic [CW-1:0] r_count;

  // The whole pipe moves together; it only stalls when a finished product is refused
  assign w_adv       = !r_out_valid || i_out_ready;
  assign o_in_ready  = w_adv;
  assign o_out_valid = r_out_valid;
  assign o_mat_count = r_count;

  // Valid bits shift alongside the data registers inside the dot2 lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_v1        <= i_in_valid;
      r_out_valid <= r_v1;
    end
  end

  // Count handoffs; wraps naturally at 2^CW
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_out_valid && i_out_ready) begin
      r_count <= r_count + 1'b1;
    end
  end

  // C00 = A00*B00 + A01*B10
  dot2 #(.W(DW)) u_c0 (
    .clk(clk), .rst(rst), .i_adv(w_adv),
    .i_x0(i_a0), .i_y0(i_b0), .i_x1(i_a1), .i_y1(i_b2),
    .o_sum(o_c0)
  );

  // C01 = A00*B01 + A01*B11
  dot2 #(.W(DW)) u_c1 (
    .clk(clk), .rst(rst), .i_adv(w_adv),
    .i_x0(i_a0), .i_y0(i_b1), .i_x1(i_a1), .i_y1(i_b3),
    .o_sum(o_c1)
  );

  // C10 = A10*B00 + A11*B10
  dot2 #(.W(DW)) u_c2 (
    .clk(clk), .rst(rst), .i_adv(w_adv),
    .i_x0(i_a2), .i_y0(i_b0), .i_x1(i_a3), .i_y1(i_b2),
    .o_sum(o_c2)
  );

  // C11 = A10*B01 + A11*B11
  dot2 #(.W(DW)) u_c3 (
    .clk(clk), .rst(rst), .i_adv(w_adv),
    .i_x0(i_a2), .i_y0(i_b1), .i_x1(i_a3), .i_y1(i_b3),
    .o_sum(o_c3)
  );

endmodule

// File: tb/tb_matmul_pipe.sv
// tb/tb_matmul_pipe.sv - self-checking bench for matmul_pipe against a matrix-product reference
module tb_matmul_pipe;
  import matmul_pkg::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  mat2_t         a_m;
  mat2_t         b_m;
  logic          in_valid;
  logic          out_ready;
  logic          in_ready;
  logic          out_valid;
  logic [SW-1:0] c0, c1, c2, c3;
  logic [CW-1:0] mat_count;
  res2_t         c_obs;

  res2_t exp_q[$];
  res2_t got_q[$];
  int    checks = 0;
  int    failures = 0;
  int    m_count = 0;

  always #5 clk = ~clk;

  assign c_obs = {c3, c2, c1, c0};

  matmul_pipe #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .i_a0(a_m[0]), .i_a1(a_m[1]), .i_a2(a_m[2]), .i_a3(a_m[3]),
    .i_b0(b_m[0]), .i_b1(b_m[1]), .i_b2(b_m[2]), .i_b3(b_m[3]),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_c0(c0), .o_c1(c1), .o_c2(c2), .o_c3(c3),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_mat_count(mat_count)
  );

  // Reference: textbook 2x2 matrix product C[i][j] = sum_k A[i][k]*B[k][j]
  function automatic res2_t model(input mat2_t a, input mat2_t b);
    res2_t r;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 2; k++) s += int'(a[i*2+k]) * int'(b[k*2+j]);
        r[i*2+j] = SW'(s);
      end
    end
    return r;
  endfunction

  function automatic mat2_t rand_mat();
    mat2_t m;
    for (int i = 0; i < 4; i++) m[i] = DW'($urandom);
    return m;
  endfunction

  // One clock: record accepts/handoffs at this edge, then land on the next falling edge
  task automatic tick();
    bit acc, ho;
    #1;
    acc = in_valid && in_ready;
    ho  = out_valid && out_ready;
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      m_count = 0;
    end else begin
      if (ho) begin
        got_q.push_back(c_obs);
        m_count = (m_count + 1) % (1 << CW);
      end
      if (acc) exp_q.push_back(model(a_m, b_m));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (c_obs !== '0) begin failures++; $display("FAIL reset_c got=%h exp=0", c_obs); end
    checks++; if (mat_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", mat_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_known();
    exp_q.delete(); got_q.delete();
    a_m = {8'd4, 8'd3, 8'd2, 8'd1};
    b_m = {8'd8, 8'd7, 8'd6, 8'd5};
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL known_early_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL known_valid got=%b exp=1", out_valid); end
    checks++;
    if (c0 !== 17'd19 || c1 !== 17'd22 || c2 !== 17'd43 || c3 !== 17'd50) begin
      failures++; $display("FAIL known_c got=%0d,%0d,%0d,%0d exp=19,22,43,50", c0, c1, c2, c3);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL known_single_valid got=%b exp=0", out_valid); end
    checks++; if (mat_count !== 8'd1) begin failures++; $display("FAIL known_count got=%0d exp=1", mat_count); end
  endtask

  task automatic test_max();
    exp_q.delete(); got_q.delete();
    a_m = {4{8'hFF}}; b_m = {4{8'hFF}};
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL max_valid got=%b exp=1", out_valid); end
    checks++;
    if (c_obs !== {4{17'h1FC02}}) begin failures++; $display("FAIL max_c got=%h exp=%h", c_obs, {4{17'h1FC02}}); end
    tick();
    checks++; if (mat_count !== 8'd2) begin failures++; $display("FAIL max_count got=%0d exp=2", mat_count); end
  endtask

  task automatic test_back_to_back();
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    a_m = {8'd1, 8'd0, 8'd0, 8'd1};
    b_m = {8'd6, 8'd7, 8'd8, 8'd9};
    tick();
    a_m = '0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || c0 !== 17'd9 || c1 !== 17'd8 || c2 !== 17'd7 || c3 !== 17'd6) begin
      failures++; $display("FAIL b2b_first got=v%b %0d,%0d,%0d,%0d exp=v1 9,8,7,6", out_valid, c0, c1, c2, c3);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || c_obs !== '0) begin
      failures++; $display("FAIL b2b_second got=v%b %h exp=v1 0", out_valid, c_obs);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", out_valid); end
    checks++; if (mat_count !== 8'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", mat_count); end
  endtask

  task automatic test_backpressure();
    res2_t hold;
    int    base;
    exp_q.delete(); got_q.delete();
    base = m_count;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_m = rand_mat(); b_m = rand_mat();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    hold = c_obs;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (c_obs !== hold) begin failures++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", i, c_obs, hold); end
      tick();
    end
    drain();
    checks++; if (got_q.size() != 3 || exp_q.size() != 3) begin failures++; $display("FAIL bp_num got=%0d exp=3 (accepted %0d)", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (mat_count !== CW'((base + 3) % (1 << CW))) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", mat_count, (base + 3) % (1 << CW)); end
  endtask

  task automatic test_reset_midflight();
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    a_m = rand_mat(); b_m = rand_mat();
    tick();
    a_m = rand_mat(); b_m = rand_mat();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmf_valid got=%b exp=0", out_valid); end
    checks++; if (mat_count !== '0) begin failures++; $display("FAIL rmf_count got=%0d exp=0", mat_count); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmf_stale cyc=%0d got=%b exp=0", i, out_valid); end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rmf_handoffs got=%0d exp=0", got_q.size()); end
    checks++; if (mat_count !== '0) begin failures++; $display("FAIL rmf_count_end got=%0d exp=0", mat_count); end
  endtask

  task automatic test_wrap();
    int base;
    exp_q.delete(); got_q.delete();
    base = m_count;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      a_m = rand_mat(); b_m = rand_mat();
      tick();
    end
    drain();
    checks++; if (got_q.size() != 257) begin failures++; $display("FAIL wrap_num got=%0d exp=257", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (mat_count !== CW'((base + 257) % (1 << CW))) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", mat_count, (base + 257) % (1 << CW)); end
  endtask

  task automatic test_random();
    int    base;
    bit    acc, was_stall;
    res2_t prev_c;
    exp_q.delete(); got_q.delete();
    base = m_count;
    a_m = rand_mat(); b_m = rand_mat();
    in_valid = ($urandom_range(9) < 7);
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(9) < 6);
      #1;
      acc       = in_valid && in_ready;
      was_stall = out_valid && !out_ready;
      prev_c    = c_obs;
      tick();
      if (was_stall) begin
        checks++;
        if (out_valid !== 1'b1 || c_obs !== prev_c) begin
          failures++; $display("FAIL rnd_hold cyc=%0d got=v%b %h exp=v1 %h", i, out_valid, c_obs, prev_c);
        end
      end
      if (acc || !in_valid) begin
        a_m = rand_mat(); b_m = rand_mat();
        in_valid = ($urandom_range(9) < 7);
      end
    end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_num got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (mat_count !== CW'((base + exp_q.size()) % (1 << CW))) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", mat_count, (base + exp_q.size()) % (1 << CW)); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_m = '0; b_m = '0;
    @(negedge clk);
    test_reset();
    test_known();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
